icache_refill: RTL
==================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 The block SHALL take parameter ADDR_W, default `MEM_SPACE`, instruction address width.
REQ-002 The block SHALL take parameter ISIZE, default 16, instruction word width.
REQ-003 The block SHALL take parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 miss  in  1  lookup-side miss for miss_addr.
REQ-007 miss_addr  in  ADDR_W  address that missed.
REQ-008 flush  in  1  request to invalidate all cache entries.
REQ-009 mem_req  out  1  instruction-memory read request.
REQ-010 mem_addr  out  ADDR_W  read address, held stable while mem_req=1.
REQ-011 mem_ack  in  1  memory data valid; ignored unless mem_req=1.
REQ-012 mem_rdata  in  ISIZE  instruction word, sampled when mem_ack=1.
REQ-013 fill_we  out  1  one-cycle cache write strobe.
REQ-014 fill_idx  out  2  entry index 0..3 written.
REQ-015 fill_tag  out  ADDR_W  address stored into the entry.
REQ-016 fill_data  out  ISIZE  instruction stored into the entry.
REQ-017 valid  out  4  per-entry valid bits, owned by this block.
REQ-018 stall  out  1  high whenever state != IDLE.
REQ-019 fill_done  out  1  one-cycle pulse after a successful fill.
REQ-020 err  out  1  sticky memory-timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, WAIT, FILL, DONE, FLUSH; all outputs registered.
REQ-022 IDLE: flush=1 -> FLUSH (flush wins over simultaneous miss); else miss=1 -> latch miss_addr into mem_addr, assert mem_req, clear timeout counter -> WAIT.
REQ-023 WAIT: mem_req=1, mem_addr stable; mem_ack=1 -> capture mem_rdata, drop mem_req -> FILL.
REQ-024 WAIT timeout: counter increments each WAIT cycle without ack; on reaching TIMEOUT, drop mem_req, set err, no write, -> IDLE; ack on the same edge as the limit SHALL win (fill proceeds).
REQ-025 FILL: fill_we=1 for exactly one cycle with fill_idx=victim, fill_tag=latched address, fill_data=captured word; set valid[victim] -> DONE.
REQ-026 Victim SHALL be the lowest-index invalid entry if any exists, else the round-robin pointer; pointer advances only when used, wrapping 3 -> 0.
REQ-027 DONE: fill_done=1 for one cycle -> IDLE.
REQ-028 FLUSH: clear all four valid bits and the round-robin pointer in one cycle -> IDLE; err unaffected.
REQ-029 miss and flush outside IDLE SHALL be ignored; the lookup side re-presents a still-pending miss.
REQ-030 Latency: miss sampled at edge N -> mem_req high after N; ack sampled at edge K -> fill_we high after K, fill_done high after K+1, stall low after K+2.
REQ-031 err SHALL clear only on reset.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE and mem_req, fill_we, fill_done, stall, err, valid, pointer, counter, mem_addr, fill_idx, fill_tag, fill_data all to 0.
REQ-033 Reset during WAIT or FILL SHALL abort without any cache write; operation resumes on the first edge after rst=1.

Verification
REQ-034 Single miss: miss=1, addr=0x10, ack 3 cycles later with 0xBEEF -> one fill_we, idx=0, tag=0x10, data=0xBEEF, valid=0001, one fill_done pulse.
REQ-035 Five sequential misses (0x10,0x20,0x30,0x40,0x50) -> idx 0,1,2,3 then 0 (wrap), valid=1111.
REQ-036 Timeout: miss, no ack for 15 WAIT cycles -> mem_req drops, err=1, no fill_we, state IDLE, valid unchanged.
REQ-037 Flush and miss same IDLE cycle -> valid=0000, no mem_req; next miss fills idx=0.
REQ-038 rst=0 asserted mid-WAIT -> mem_req=0 immediately, no fill_we; post-reset miss completes normally.

Source files
------------

// File: rtl/icache_refill.sv
// icache_refill: miss-driven refill FSM for a 4-entry instruction cache with timeout and flush.
`ifndef MEM_SPACE
`define MEM_SPACE 16
`endif

module icache_refill #(
    parameter int ADDR_W  = `MEM_SPACE,
    parameter int ISIZE   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ISIZE-1:0]  mem_rdata,
    output logic              fill_we,
    output logic [1:0]        fill_idx,
    output logic [ADDR_W-1:0] fill_tag,
    output logic [ISIZE-1:0]  fill_data,
    output logic [3:0]        valid,
    output logic              stall,
    output logic              fill_done,
    output logic              err
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT, FILL, DONE, FLUSH} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [1:0]        ptr, ptr_n, victim;
    logic              req_n, we_n, done_n, err_n;
    logic [ADDR_W-1:0] addr_n, tag_n;
    logic [ISIZE-1:0]  data_n;
    logic [1:0]        idx_n;
    logic [3:0]        valid_n;

    // Lowest invalid entry wins; the round-robin pointer is only a fallback when all are valid.
    always_comb begin
        victim = ptr;
        for (int i = 3; i >= 0; i--) if (!valid[i]) victim = 2'(i);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        req_n   = mem_req;
        addr_n  = mem_addr;
        err_n   = err;
        we_n    = 1'b0;
        done_n  = 1'b0;
        idx_n   = fill_idx;
        tag_n   = fill_tag;
        data_n  = fill_data;
        valid_n = valid;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_n = FLUSH;
                end else if (miss) begin
                    state_n = WAIT;
                    req_n   = 1'b1;
                    addr_n  = miss_addr;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_n = FILL;
                    req_n   = 1'b0;
                    we_n    = 1'b1;
                    idx_n   = victim;
                    tag_n   = mem_addr;
                    data_n  = mem_rdata;
                end else if (cnt == LIM) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FILL: begin
                state_n           = DONE;
                done_n            = 1'b1;
                valid_n[fill_idx] = 1'b1;
                // valid cannot change between victim choice and here, so &valid means the pointer was used
                ptr_n             = (&valid) ? ptr + 2'd1 : ptr;
            end
            DONE:  state_n = IDLE;
            FLUSH: begin
                state_n = IDLE;
                valid_n = '0;
                ptr_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            err       <= 1'b0;
            fill_we   <= 1'b0;
            fill_done <= 1'b0;
            fill_idx  <= '0;
            fill_tag  <= '0;
            fill_data <= '0;
            valid     <= '0;
            stall     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            mem_req   <= req_n;
            mem_addr  <= addr_n;
            err       <= err_n;
            fill_we   <= we_n;
            fill_done <= done_n;
            fill_idx  <= idx_n;
            fill_tag  <= tag_n;
            fill_data <= data_n;
            valid     <= valid_n;
            stall     <= state_n != IDLE;
        end
    end
endmodule
